// File: rtl/ntt_pkg.sv
// Shared constants and types for the NTT front end (gather stage and bit-reversal network).
package ntt_pkg;
  localparam int SIZE   = 256;
  localparam int WIDTH  = 32;
  localparam int PERM_W = 8;
  localparam int IDX_W  = $clog2(SIZE);

  typedef logic [WIDTH-1:0] coeff_t;
  typedef coeff_t [SIZE-1:0] frame_t;

  typedef enum logic [1:0] {FILL, PAD, FULL} gather_state_t;
endpackage

// File: rtl/ntt_coeff_gather.sv
// Serial-to-parallel coefficient gather: builds a zero-padded SIZE-entry frame from a
// valid/ready stream and holds it, with its permutation config, until the consumer takes it.
module ntt_coeff_gather #(
  parameter int SIZE   = ntt_pkg::SIZE,
  parameter int WIDTH  = ntt_pkg::WIDTH,
  parameter int PERM_W = ntt_pkg::PERM_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [WIDTH-1:0]            s_data,
  input  logic                        s_last,
  input  logic [PERM_W-1:0]           s_perm_enable,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [SIZE-1:0][WIDTH-1:0]  m_data,
  output logic [PERM_W-1:0]           m_perm_enable,
  output logic [$clog2(SIZE):0]       m_count,
  output logic                        m_len_err
);
  import ntt_pkg::gather_state_t;
  import ntt_pkg::FILL;
  import ntt_pkg::PAD;
  import ntt_pkg::FULL;

  localparam int IW = $clog2(SIZE);
  localparam int CW = IW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);

  gather_state_t state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [SIZE-1:0][WIDTH-1:0] frame_buf;
  logic wr_en;
  logic [WIDTH-1:0] wr_data;
  logic accept;
  logic at_end;

  assign s_ready = (state == FILL) && !rst;
  assign accept  = s_valid && s_ready;
  assign at_end  = (idx == LAST_IDX);
  assign m_valid = (state == FULL);
  assign m_data  = frame_buf;

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    wr_en    = 1'b0;
    wr_data  = s_data;
    case (state)
      FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          if (at_end) begin
            state_nx = FULL;
          end else begin
            idx_nx = idx + 1'b1;
            if (s_last) state_nx = PAD;
          end
        end
      end
      PAD: begin
        // Zero the tail so a short frame never exposes data from an earlier frame.
        wr_en   = 1'b1;
        wr_data = '0;
        if (at_end) state_nx = FULL;
        else        idx_nx   = idx + 1'b1;
      end
      FULL: begin
        if (m_ready) begin
          idx_nx   = '0;
          state_nx = FILL;
        end
      end
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FILL;
      idx           <= '0;
      m_count       <= '0;
      m_perm_enable <= '0;
      m_len_err     <= 1'b0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      if (accept && (idx == '0)) m_perm_enable <= s_perm_enable;
      if (accept && (at_end || s_last)) begin
        m_count   <= at_end ? CW'(SIZE) : ({1'b0, idx} + CW'(1));
        m_len_err <= at_end && !s_last;
      end
    end
  end

  // Frame storage carries no reset; its content only matters while m_valid is high.
  always_ff @(posedge clk) begin
    if (wr_en) frame_buf[idx] <= wr_data;
  end
endmodule

// File: tb/tb_ntt_coeff_gather.sv
// Scoreboard bench for ntt_coeff_gather: a frame-level model queues expected frames,
// an independent monitor compares every presented frame and its timing.
module tb_ntt_coeff_gather;
  import ntt_pkg::*;

  localparam int CW = IDX_W + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid = 1'b0;
  logic s_last = 1'b0;
  logic m_ready = 1'b0;
  logic [WIDTH-1:0] s_data = '0;
  logic [PERM_W-1:0] s_perm_enable = '0;
  logic s_ready;
  logic m_valid;
  frame_t m_data;
  logic [PERM_W-1:0] m_perm_enable;
  logic [CW-1:0] m_count;
  logic m_len_err;

  ntt_coeff_gather dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .s_perm_enable(s_perm_enable),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_perm_enable(m_perm_enable), .m_count(m_count), .m_len_err(m_len_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    frame_t           data;
    int               count;
    logic [PERM_W-1:0] perm;
    bit               len_err;
    int               exp_cyc;
  } exp_t;

  exp_t sbq[$];
  logic [WIDTH-1:0] cur[$];
  logic [PERM_W-1:0] cur_perm;
  int n_cmp = 0;
  int n_bad = 0;
  bit bp_mode = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level reference: a frame ends at SIZE beats or at s_last; the tail is zero.
  task automatic model_accept(input logic [WIDTH-1:0] d, input bit last,
                              input logic [PERM_W-1:0] p);
    exp_t e;
    int k;
    if (cur.size() == 0) cur_perm = p;
    cur.push_back(d);
    if (cur.size() == SIZE || last) begin
      k = cur.size() - 1;
      e.data = '0;
      for (int i = 0; i < cur.size(); i++) e.data[i] = cur[i];
      e.count   = cur.size();
      e.perm    = cur_perm;
      e.len_err = (cur.size() == SIZE) && !last;
      e.exp_cyc = cyc + SIZE - k;
      sbq.push_back(e);
      cur.delete();
    end
  endtask

  task automatic send_beat(input logic [WIDTH-1:0] d, input bit last,
                           input logic [PERM_W-1:0] p);
    int waited = 0;
    bit done = 1'b0;
    s_valid = 1'b1; s_data = d; s_last = last; s_perm_enable = p;
    while (!done) begin
      @(negedge clk);
      if (s_ready) begin
        model_accept(d, last, p);
        done = 1'b1;
      end else if (++waited > 3000) begin
        n_cmp++; n_bad++;
        $display("FAIL beat_accept: not accepted after %0d cycles, want accept", waited);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(input int n, input int base, input bit rnd, input bit last_at_end,
                            input logic [PERM_W-1:0] p, input bit gaps);
    for (int i = 0; i < n; i++) begin
      send_beat(rnd ? WIDTH'($urandom) : WIDTH'(base + i), last_at_end && (i == n - 1), p);
      if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int w = 0;
    while (sbq.size() != 0 && w < 5000) begin
      @(posedge clk); w++;
    end
    chk("drain_pending", sbq.size(), 0);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (cycles) begin
      @(negedge clk);
      chk("rst_s_ready", s_ready, 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    cur.delete();
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_count", m_count, 0);
    chk("rst_m_perm", m_perm_enable, 0);
    chk("rst_m_len_err", m_len_err, 0);
    chk("rst_exit_s_ready", s_ready, 1);
    @(posedge clk); #1;
  endtask

  // Consumer: random acceptance, or stalled entirely while bp_mode is set.
  initial begin
    forever begin
      @(posedge clk); #1;
      m_ready = bp_mode ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compares each cycle a frame is presented, so a held frame must stay stable.
  initial begin
    bit prev_v = 1'b0;
    bit hs_prev = 1'b0;
    exp_t e;
    int bad_i;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0; hs_prev = 1'b0;
      end else begin
        if (hs_prev) begin
          chk("post_hs_s_ready", s_ready, 1);
          chk("post_hs_m_valid", m_valid, 0);
        end
        if (m_valid) begin
          chk("full_s_ready", s_ready, 0);
          if (sbq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_frame: m_valid=1 with no frame expected (cycle %0d)", cyc);
          end else begin
            e = sbq[0];
            bad_i = -1;
            for (int i = 0; i < SIZE; i++)
              if (bad_i < 0 && m_data[i] !== e.data[i]) bad_i = i;
            n_cmp++;
            if (bad_i >= 0) begin
              n_bad++;
              $display("FAIL frame_data: entry %0d got %0h want %0h", bad_i,
                       m_data[bad_i], e.data[bad_i]);
            end
            chk("m_count", m_count, e.count);
            chk("m_perm_enable", m_perm_enable, e.perm);
            chk("m_len_err", m_len_err, e.len_err);
            if (!prev_v) chk("valid_latency_cycle", cyc, e.exp_cyc);
            if (m_ready) void'(sbq.pop_front());
          end
        end
        hs_prev = m_valid && m_ready;
        prev_v  = m_valid;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t snap;
    int w;
    do_reset(3);

    // Full frame, ramp data.
    send_frame(SIZE, 0, 1'b0, 1'b1, 8'hFE, 1'b0);
    drain();

    // Short frame: 10 beats.
    send_frame(10, 100, 1'b0, 1'b1, 8'h35, 1'b0);
    drain();

    // Overlong: 300 beats without s_last, then one closing beat for the spill-over frame.
    send_frame(300, 1000, 1'b0, 1'b0, 8'h5A, 1'b0);
    send_beat(32'hCAFE, 1'b1, 8'h11);
    drain();

    // Backpressure: stall the consumer for 50 cycles in FULL.
    bp_mode = 1'b1;
    send_frame(20, 0, 1'b1, 1'b1, 8'hA3, 1'b0);
    w = 0;
    while (!m_valid && w < 600) begin
      @(negedge clk); w++;
    end
    chk("bp_valid_seen", m_valid, 1);
    snap = m_data;
    repeat (50) begin
      @(negedge clk);
      chk("bp_m_valid_held", m_valid, 1);
      chk("bp_s_ready_low", s_ready, 0);
      chk("bp_data_stable", (m_data === snap) ? 1 : 0, 1);
    end
    @(posedge clk); #1;
    bp_mode = 1'b0;
    send_frame(7, 0, 1'b1, 1'b1, 8'h4C, 1'b0);
    drain();

    // Reset after 40 beats; the partial frame must vanish.
    send_frame(40, 500, 1'b0, 1'b0, 8'h77, 1'b0);
    do_reset(1);
    send_frame(5, 0, 1'b1, 1'b1, 8'h0F, 1'b0);
    drain();

    // Single-beat frame.
    send_beat(32'd7, 1'b1, 8'h81);
    drain();

    // Random frames with idle gaps.
    for (int f = 0; f < 4; f++)
      send_frame($urandom_range(1, 300), 0, 1'b1, 1'b1, PERM_W'($urandom), 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
